prbs5_checker: RTL and testbench

- Receive-side checker for the 5-bit PRBS generator: consumes the serial bit stream taken from the generator's out[0], one bit per accepted cycle.
- Self-synchronises to the x^5+x^2+1 sequence (recurrence b[n] = b[n-5] ^ b[n-3], period 31), declares lock, then counts bit errors.
- Drops lock on excessive errors. Sits at the far end of the test link, feeding status LEDs/HEX counters.

---
 rtl/prbs5_checker.sv | 163 ++++++++++++++++
 tb/tb_prbs5_checker.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs5_checker.sv
// Receive-side checker for the x^5+x^2+1 PRBS stream: self-synchronises to the
// sequence, declares lock, counts bit errors and drops lock on error bursts.
module prbs5_checker #(
    parameter int LOCK_MATCHES = 8,
    parameter int UNLOCK_ERRS  = 4,
    parameter int ERR_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             sync_loss
);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [4:0]       LOCK_MATCHES_C = 5'(LOCK_MATCHES);
    localparam logic [4:0]       UNLOCK_ERRS_C  = 5'(UNLOCK_ERRS);
    localparam logic [4:0]       WIN_LAST       = 5'd30;
    localparam logic [ERR_W-1:0] ERR_MAX        = '1;

    state_t           state_reg,     state_next;
    logic [4:0]       hist_reg,      hist_next;
    logic [2:0]       fill_cnt_reg,  fill_cnt_next;
    logic [4:0]       match_cnt_reg, match_cnt_next;
    logic [4:0]       win_bits_reg,  win_bits_next;
    logic [4:0]       win_err_reg,   win_err_next;
    logic [ERR_W-1:0] err_count_reg, err_count_next;
    logic             err_pulse_reg, err_pulse_next;
    logic             sync_loss_reg, sync_loss_next;
    logic             locked_reg,    locked_next;

    logic             pred;
    logic             mismatch;
    logic [4:0]       hist_shifted;
    logic [4:0]       win_err_after;
    logic [ERR_W-1:0] err_count_base;

    // History moved up one place; the newest slot is filled by the caller.
    assign hist_shifted[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 5; gi++) begin : g_shift
            assign hist_shifted[gi] = hist_reg[gi-1];
        end
    endgenerate

    assign pred     = hist_reg[4] ^ hist_reg[2];
    assign mismatch = (bit_in != pred);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= SEED;
            hist_reg      <= '0;
            fill_cnt_reg  <= '0;
            match_cnt_reg <= '0;
            win_bits_reg  <= '0;
            win_err_reg   <= '0;
            err_count_reg <= '0;
            err_pulse_reg <= 1'b0;
            sync_loss_reg <= 1'b0;
            locked_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hist_reg      <= hist_next;
            fill_cnt_reg  <= fill_cnt_next;
            match_cnt_reg <= match_cnt_next;
            win_bits_reg  <= win_bits_next;
            win_err_reg   <= win_err_next;
            err_count_reg <= err_count_next;
            err_pulse_reg <= err_pulse_next;
            sync_loss_reg <= sync_loss_next;
            locked_reg    <= locked_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        hist_next      = hist_reg;
        fill_cnt_next  = fill_cnt_reg;
        match_cnt_next = match_cnt_reg;
        win_bits_next  = win_bits_reg;
        win_err_next   = win_err_reg;
        err_pulse_next = 1'b0;
        sync_loss_next = 1'b0;
        win_err_after  = win_err_reg;
        // Clear takes effect before any increment in the same cycle.
        err_count_base = err_clr ? '0 : err_count_reg;
        err_count_next = err_count_base;

        if (bit_valid) begin
            unique case (state_reg)
                SEED: begin
                    hist_next     = hist_shifted | {4'b0000, bit_in};
                    fill_cnt_next = fill_cnt_reg + 3'd1;
                    if (fill_cnt_reg == 3'd4) begin
                        state_next     = HUNT;
                        match_cnt_next = '0;
                    end
                end

                HUNT: begin
                    hist_next = hist_shifted | {4'b0000, bit_in};
                    // The all-zero history is a fixed point of the recurrence, never lock on it.
                    if (!mismatch && (hist_next != 5'b00000)) begin
                        match_cnt_next = match_cnt_reg + 5'd1;
                    end else begin
                        match_cnt_next = '0;
                    end
                    if (match_cnt_next == LOCK_MATCHES_C) begin
                        state_next    = LOCKED;
                        win_bits_next = '0;
                        win_err_next  = '0;
                    end
                end

                LOCKED: begin
                    // Free-running reference so that a flipped bit is counted only once.
                    hist_next = hist_shifted | {4'b0000, pred};
                    if (mismatch) begin
                        err_pulse_next = 1'b1;
                        win_err_after  = win_err_reg + 5'd1;
                        if (err_count_base != ERR_MAX) begin
                            err_count_next = err_count_base + 1'b1;
                        end
                    end
                    if (win_bits_reg == WIN_LAST) begin
                        win_bits_next = '0;
                        win_err_after = mismatch ? 5'd1 : 5'd0;
                    end else begin
                        win_bits_next = win_bits_reg + 5'd1;
                    end
                    win_err_next = win_err_after;
                    if (mismatch && (win_err_after >= UNLOCK_ERRS_C)) begin
                        state_next     = SEED;
                        fill_cnt_next  = '0;
                        sync_loss_next = 1'b1;
                    end
                end

                default: begin
                    state_next    = SEED;
                    fill_cnt_next = '0;
                end
            endcase
        end

        locked_next = (state_next == LOCKED);
    end

    assign locked    = locked_reg;
    assign err_pulse = err_pulse_reg;
    assign err_count = err_count_reg;
    assign sync_loss = sync_loss_reg;

endmodule

// File: tb/tb_prbs5_checker.sv
// Scoreboard bench for prbs5_checker: a queue-based reference model predicts every
// cycle's outputs; a monitor process compares them after each clock edge.
module tb_prbs5_checker;

    localparam int LOCK_MATCHES = 8;
    localparam int UNLOCK_ERRS  = 4;
    localparam int ERR_W        = 5;
    localparam int CNT_MAX      = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             bit_valid = 1'b0;
    logic             bit_in = 1'b0;
    logic             err_clr = 1'b0;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic             sync_loss;

    always #5 clk = ~clk;

    prbs5_checker #(
        .LOCK_MATCHES(LOCK_MATCHES),
        .UNLOCK_ERRS (UNLOCK_ERRS),
        .ERR_W       (ERR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bit_valid(bit_valid),
        .bit_in   (bit_in),
        .err_clr  (err_clr),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_count(err_count),
        .sync_loss(sync_loss)
    );

    typedef struct packed {
        logic             locked;
        logic             err_pulse;
        logic             sync_loss;
        logic [ERR_W-1:0] err_count;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: mode 0 = seeding, 1 = hunting, 2 = locked.
    int   m_mode, m_fill, m_match, m_wbits, m_werr, m_cnt;
    bit   m_last5[$];
    bit   prbs[31];
    int   sidx;

    function automatic void model_reset();
        m_last5 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        m_mode  = 0;
        m_fill  = 0;
        m_match = 0;
        m_wbits = 0;
        m_werr  = 0;
        m_cnt   = 0;
    endfunction

    function automatic void shift_in(bit b);
        m_last5.push_back(b);
        void'(m_last5.pop_front());
    endfunction

    function automatic bit last5_all_zero();
        bit any_one;
        any_one = 1'b0;
        foreach (m_last5[k]) any_one |= m_last5[k];
        return !any_one;
    endfunction

    function automatic void model_step(bit rst, bit v, bit b, bit clr);
        exp_t e;
        bit p, err, pulse, sl;
        pulse = 1'b0;
        sl    = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            if (clr) m_cnt = 0;
            if (v) begin
                p = m_last5[0] ^ m_last5[2];  // b[n-5] ^ b[n-3]
                case (m_mode)
                    0: begin
                        shift_in(b);
                        m_fill++;
                        if (m_fill == 5) begin
                            m_mode  = 1;
                            m_match = 0;
                        end
                    end
                    1: begin
                        shift_in(b);
                        if (b == p && !last5_all_zero()) m_match++;
                        else m_match = 0;
                        if (m_match == LOCK_MATCHES) begin
                            m_mode  = 2;
                            m_wbits = 0;
                            m_werr  = 0;
                        end
                    end
                    default: begin
                        shift_in(p);
                        err = (b != p);
                        if (err) begin
                            pulse = 1'b1;
                            if (m_cnt < CNT_MAX) m_cnt++;
                            m_werr++;
                        end
                        m_wbits++;
                        if (m_wbits == 31) begin
                            m_wbits = 0;
                            m_werr  = err ? 1 : 0;
                        end
                        if (err && m_werr >= UNLOCK_ERRS) begin
                            m_mode = 0;
                            m_fill = 0;
                            sl     = 1'b1;
                        end
                    end
                endcase
            end
        end
        e.locked    = (m_mode == 2);
        e.err_pulse = pulse;
        e.sync_loss = sl;
        e.err_count = ERR_W'(m_cnt);
        exp_q.push_back(e);
    endfunction

    function automatic void chk(string name, logic [31:0] got, logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endfunction

    // Monitor: one expected tuple per driven cycle, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({locked, err_pulse, sync_loss, err_count} !== e) begin
                    failures++;
                    $display("FAIL scoreboard t=%0t: got locked=%b pulse=%b loss=%b cnt=%0d expected locked=%b pulse=%b loss=%b cnt=%0d",
                             $time, locked, err_pulse, sync_loss, err_count,
                             e.locked, e.err_pulse, e.sync_loss, e.err_count);
                end
            end
        end
    end

    task automatic step(input bit rst, input bit v, input bit b, input bit clr);
        @(negedge clk);
        reset     = rst;
        bit_valid = v;
        bit_in    = b;
        err_clr   = clr;
        model_step(rst, v, b, clr);
    endtask

    task automatic send(input bit flip, input bit clr);
        bit b;
        b = prbs[sidx % 31] ^ flip;
        sidx++;
        step(1'b0, 1'b1, b, clr);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        sidx = 0;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int r;
        int burst;
        bit rst, v, flip, clr, b;

        prbs[0] = 1'b1;
        for (int n = 1; n < 5; n++) prbs[n] = 1'b0;
        for (int n = 5; n < 31; n++) prbs[n] = prbs[n-5] ^ prbs[n-3];
        model_reset();

        // Reset state.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        after_edge();
        chk("reset_locked", locked, 0);
        chk("reset_pulse", err_pulse, 0);
        chk("reset_loss", sync_loss, 0);
        chk("reset_count", err_count, 0);
        $display("txn reset: locked=%b cnt=%0d", locked, err_count);

        // Clean stream: lock after bit index 12, no errors over 200 bits.
        for (int i = 0; i < 200; i++) begin
            send(1'b0, 1'b0);
            if (i == 11) begin after_edge(); chk("lock_before_12", locked, 0); end
            if (i == 12) begin after_edge(); chk("lock_at_12", locked, 1); end
        end
        after_edge();
        chk("clean_count", err_count, 0);
        $display("txn clean_stream: locked=%b cnt=%0d", locked, err_count);

        // Single flipped bit at index 40.
        do_reset();
        for (int i = 0; i < 80; i++) begin
            send(i == 40, 1'b0);
            if (i == 40) begin
                after_edge();
                chk("single_pulse", err_pulse, 1);
                chk("single_count", err_count, 1);
                chk("single_locked", locked, 1);
            end
            if (i == 41) begin after_edge(); chk("single_no_repulse", err_pulse, 0); end
        end
        after_edge();
        chk("single_final_count", err_count, 1);
        $display("txn single_error: locked=%b cnt=%0d", locked, err_count);

        // Four errors in one window force loss of lock, then relock 13 bits later.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            send(i == 50 || i == 55 || i == 60 || i == 65, 1'b0);
            if (i == 65) begin
                after_edge();
                chk("burst_unlocked", locked, 0);
                chk("burst_sync_loss", sync_loss, 1);
                chk("burst_pulse", err_pulse, 1);
                chk("burst_count", err_count, 4);
            end
            if (i == 77) begin after_edge(); chk("relock_not_yet", locked, 0); end
            if (i == 78) begin after_edge(); chk("relock_13", locked, 1); end
        end
        $display("txn unlock_relock: locked=%b cnt=%0d", locked, err_count);

        // Three errors per window: stay locked; then keep going to saturate the count.
        do_reset();
        for (int i = 0; i < 13 + 31 * 12; i++) begin
            r = i - 13;
            send(i >= 13 && (r % 31) >= 5 && (r % 31) <= 7, 1'b0);
            if (i == 13 + 31 * 5 - 1) begin
                after_edge();
                chk("three_per_win_count", err_count, 15);
                chk("three_per_win_locked", locked, 1);
            end
        end
        after_edge();
        chk("saturated_count", err_count, CNT_MAX);
        chk("saturated_locked", locked, 1);
        $display("txn three_per_window: locked=%b cnt=%0d", locked, err_count);

        // All-zero input never locks.
        do_reset();
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        after_edge();
        chk("zeros_no_lock", locked, 0);
        $display("txn all_zero: locked=%b", locked);

        // bit_valid toggling: lock on the 13th accepted bit, hold cycles change nothing.
        do_reset();
        for (int acc = 1; acc <= 13; acc++) begin
            send(1'b0, 1'b0);
            if (acc == 12) begin after_edge(); chk("gapped_before_13", locked, 0); end
            if (acc == 13) begin after_edge(); chk("gapped_lock_13", locked, 1); end
            step(1'b0, 1'b0, 1'($urandom), 1'b0);
        end
        $display("txn gapped_valid: locked=%b", locked);

        // err_clr coinciding with an error, then reset while locked.
        do_reset();
        for (int i = 0; i <= 80; i++) begin
            r = i - 13;
            send(i >= 13 && (r % 31) >= 5 && (r % 31) <= 7, 1'b0);
        end
        after_edge();
        chk("pre_clear_count", err_count, 7);
        send(1'b1, 1'b1);
        after_edge();
        chk("clear_with_error", err_count, 1);
        chk("clear_with_error_pulse", err_pulse, 1);
        send(1'b0, 1'b1);
        after_edge();
        chk("clear_only", err_count, 0);
        chk("clear_keeps_lock", locked, 1);
        send(1'b1, 1'b0);
        step(1'b1, 1'b1, ~prbs[sidx % 31], 1'b1);
        after_edge();
        chk("midrun_reset_locked", locked, 0);
        chk("midrun_reset_pulse", err_pulse, 0);
        chk("midrun_reset_count", err_count, 0);
        chk("midrun_reset_loss", sync_loss, 0);
        $display("txn clear_and_reset: locked=%b cnt=%0d", locked, err_count);

        // Randomised traffic against the model.
        do_reset();
        burst = 0;
        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom % 600) == 0;
            v   = ($urandom % 4) != 0;
            clr = ($urandom % 60) == 0;
            if (burst == 0 && ($urandom % 300) == 0) burst = $urandom_range(5, 20);
            flip = (($urandom % 40) == 0) || (burst > 0 && $urandom % 2 == 1);
            b    = v ? (prbs[sidx % 31] ^ flip) : 1'($urandom);
            step(rst, v, b, clr);
            if (v) begin
                sidx++;
                if (burst > 0) burst--;
            end
        end
        $display("txn random: locked=%b cnt=%0d", locked, err_count);

        step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
